// File: rtl/gen_pipe_elastic_pkg.sv
// Shared constants for the elastic pipeline register family.
package gen_pipe_elastic_pkg;
    localparam logic RST_LEVEL       = 1'b1;
    localparam int   PIPE_NSTAGE_MAX = 4;
endpackage

// File: rtl/gen_pipe_elastic_slot.sv
// One 2-entry skid slot: main register plus a skid register, so in_ready
// comes straight from a flop and never depends on out_ready.
import gen_pipe_elastic_pkg::*;

module gen_pipe_elastic_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] def_val,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);
    logic          m_valid, s_valid;
    logic [DW-1:0] m_data, s_data;
    logic          in_fire, out_fire;

    assign in_ready  = ~s_valid;
    assign in_fire   = in_valid & ~s_valid;
    assign out_fire  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign busy      = m_valid | s_valid;

    always_ff @(posedge clk) begin
        if (rst == RST_LEVEL || flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= def_val;
        end else if (!s_valid) begin
            if (in_fire && (!m_valid || out_fire)) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
            end else if (in_fire && m_valid && !out_ready) begin
                s_valid <= 1'b1;
                s_data  <= in_data;
            end else if (!in_fire && out_fire) begin
                // Emptied main reloads the bubble value so out_data tracks def_val
                m_valid <= 1'b0;
                m_data  <= def_val;
            end
        end else if (out_fire) begin
            m_data  <= s_data;
            s_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/gen_pipe_elastic.sv
// Elastic pipeline register: NSTAGE chained skid slots, full throughput,
// registered in_ready, flush turns every slot into a def_val bubble.
import gen_pipe_elastic_pkg::*;

module gen_pipe_elastic #(
    parameter int DW     = 32,
    parameter int NSTAGE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] def_val,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy
);
    if (NSTAGE < 1 || NSTAGE > PIPE_NSTAGE_MAX) begin : g_bad_nstage
        $fatal(1, "gen_pipe_elastic: NSTAGE must be 1..4");
    end

    // Index k is the boundary feeding slot k; index NSTAGE is the output port.
    logic [NSTAGE:0]         v, r;
    logic [NSTAGE:0][DW-1:0] d;
    logic [NSTAGE-1:0]       b;

    assign v[0]      = in_valid;
    assign d[0]      = in_data;
    assign in_ready  = r[0];
    assign out_valid = v[NSTAGE];
    assign out_data  = d[NSTAGE];
    assign r[NSTAGE] = out_ready;
    assign busy      = |b;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
        gen_pipe_elastic_slot #(.DW(DW)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .def_val   (def_val),
            .in_valid  (v[k]),
            .in_data   (d[k]),
            .in_ready  (r[k]),
            .out_valid (v[k+1]),
            .out_data  (d[k+1]),
            .out_ready (r[k+1]),
            .busy      (b[k])
        );
    end
endmodule
